// File: rtl/alu_control.sv
// Purpose: RV32I main decoder + ALU decoder (lw, sw, R-type, I-type ALU, beq, jal).
// Latency: control outputs are registered, 1 cycle after op/funct sampling; PCSrc is combinational.
// Backpressure: none; a new decode is accepted every clock.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   op, funct3, funct7   instruction fields instr[6:0], instr[14:12], instr[30]
//   zero                 live ALU zero flag for the executing instruction
//   PCSrc                (branch & zero) | jump
//   jump, branch         jal / beq in execution
//   ALUSrc               operand B from immediate
//   RegWrite, MemWrite   register file / data memory write enables
//   ImmSrc               00 I, 01 S, 10 B, 11 J
//   ALUControl           000 add, 001 sub, 010 and, 011 or, 101 slt
module alu_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       zero,
   output logic       PCSrc,
   output logic       jump,
   output logic       ALUSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       branch,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   logic       dec_jump;
   logic       dec_alusrc;
   logic       dec_regwrite;
   logic       dec_memwrite;
   logic       dec_branch;
   logic [1:0] dec_immsrc;
   logic [1:0] dec_aluop;
   logic [2:0] dec_alucontrol;

   // Main decoder. Unknown opcodes fall through to the all-zero NOP decode.
   always_comb begin
      dec_jump     = 1'b0;
      dec_alusrc   = 1'b0;
      dec_regwrite = 1'b0;
      dec_memwrite = 1'b0;
      dec_branch   = 1'b0;
      dec_immsrc   = 2'b00;
      dec_aluop    = 2'b00;
      case (op)
         OP_LW: begin
            dec_regwrite = 1'b1;
            dec_alusrc   = 1'b1;
         end
         OP_SW: begin
            dec_immsrc   = 2'b01;
            dec_alusrc   = 1'b1;
            dec_memwrite = 1'b1;
         end
         OP_R: begin
            dec_regwrite = 1'b1;
            dec_aluop    = 2'b10;
         end
         OP_IALU: begin
            dec_regwrite = 1'b1;
            dec_alusrc   = 1'b1;
            dec_aluop    = 2'b10;
         end
         OP_BEQ: begin
            dec_immsrc   = 2'b10;
            dec_branch   = 1'b1;
            dec_aluop    = 2'b01;
         end
         OP_JAL: begin
            dec_regwrite = 1'b1;
            dec_immsrc   = 2'b11;
            dec_jump     = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decoder. For funct3=000 only the R-type form (op[5]=1) with
   // instr[30]=1 is a subtract; addi shares funct3 but must always add.
   always_comb begin
      dec_alucontrol = 3'b000;
      case (dec_aluop)
         2'b01: dec_alucontrol = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  dec_alucontrol = (op[5] & funct7) ? 3'b001 : 3'b000;
               3'b010:  dec_alucontrol = 3'b101;
               3'b110:  dec_alucontrol = 3'b011;
               3'b111:  dec_alucontrol = 3'b010;
               default: dec_alucontrol = 3'b000;
            endcase
         end
         default: dec_alucontrol = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         jump       <= 1'b0;
         ALUSrc     <= 1'b0;
         RegWrite   <= 1'b0;
         MemWrite   <= 1'b0;
         branch     <= 1'b0;
         ImmSrc     <= 2'b00;
         ALUControl <= 3'b000;
      end else begin
         jump       <= dec_jump;
         ALUSrc     <= dec_alusrc;
         RegWrite   <= dec_regwrite;
         MemWrite   <= dec_memwrite;
         branch     <= dec_branch;
         ImmSrc     <= dec_immsrc;
         ALUControl <= dec_alucontrol;
      end
   end

   // Uses the live zero flag so a taken beq redirects in the same cycle.
   assign PCSrc = (branch & zero) | jump;

endmodule

// File: tb/tb_alu_control.sv
module tb_alu_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7;
   logic       zero;
   logic       PCSrc, jump, ALUSrc, RegWrite, MemWrite, branch;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;

   int total = 0;
   int bad   = 0;

   alu_control dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
      .zero(zero), .PCSrc(PCSrc), .jump(jump), .ALUSrc(ALUSrc),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .branch(branch),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   // Packed view: {RegWrite, ImmSrc, ALUSrc, MemWrite, branch, jump, ALUControl}
   function automatic logic [9:0] dut_vec();
      return {RegWrite, ImmSrc, ALUSrc, MemWrite, branch, jump, ALUControl};
   endfunction

   // Reference: straight from the instruction-class table.
   function automatic logic [9:0] ref_decode(input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7);
      logic       rw, as, mw, br, jp, alu_class;
      logic [1:0] imm;
      logic [2:0] alu;
      rw = 0; as = 0; mw = 0; br = 0; jp = 0; imm = 2'b00; alu = 3'b000; alu_class = 0;
      if (o == 7'b0000011) begin rw = 1; as = 1; end
      else if (o == 7'b0100011) begin as = 1; mw = 1; imm = 2'b01; end
      else if (o == 7'b0110011) begin rw = 1; alu_class = 1; end
      else if (o == 7'b0010011) begin rw = 1; as = 1; alu_class = 1; end
      else if (o == 7'b1100011) begin br = 1; imm = 2'b10; alu = 3'b001; end
      else if (o == 7'b1101111) begin rw = 1; jp = 1; imm = 2'b11; end
      if (alu_class) begin
         if (f3 == 3'd0)      alu = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
         else if (f3 == 3'd2) alu = 3'b101;
         else if (f3 == 3'd6) alu = 3'b011;
         else if (f3 == 3'd7) alu = 3'b010;
      end
      return {rw, imm, as, mw, br, jp, alu};
   endfunction

   logic [9:0] exp_vec;
   logic       model_valid = 1'b0;

   always @(posedge clk) begin
      if (reset === 1'b1) begin
         exp_vec     = 10'd0;
         model_valid = 1'b1;
      end else begin
         exp_vec = ref_decode(op, funct3, funct7);
      end
   end

   // Per-cycle compare away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         total = total + 1;
         if (dut_vec() !== exp_vec) begin
            bad = bad + 1;
            $display("FAIL cyc_ctrl: got %b want %b (op=%b f3=%b f7=%b)",
                     dut_vec(), exp_vec, op, funct3, funct7);
         end
         total = total + 1;
         if (PCSrc !== ((exp_vec[4] & zero) | exp_vec[3])) begin
            bad = bad + 1;
            $display("FAIL cyc_pcsrc: got %b want %b", PCSrc, (exp_vec[4] & zero) | exp_vec[3]);
         end
      end
   end

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
      total = total + 1;
      if (got !== want) begin
         bad = bad + 1;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   // Drive after an edge, then sample the registered result 2 units after the next edge.
   task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z);
      @(posedge clk); #1;
      op = o; funct3 = f3; funct7 = f7; zero = z;
      @(posedge clk); #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b1; zero = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("reset_ctrl", dut_vec(), 10'b0);
      check("reset_pcsrc", {9'd0, PCSrc}, 10'd0);
      #1 reset = 0;
      @(posedge clk); #2;
      check("post_reset_rsub", dut_vec(), 10'b1_00_0_0_0_0_001);

      apply(7'b0000011, 3'b010, 1'b0, 1'b0);
      check("lw", dut_vec(), 10'b1_00_1_0_0_0_000);
      check("lw_pcsrc", {9'd0, PCSrc}, 10'd0);
      apply(7'b0100011, 3'b010, 1'b1, 1'b1);
      check("sw", dut_vec(), 10'b0_01_1_1_0_0_000);
      apply(7'b1100011, 3'b000, 1'b0, 1'b1);
      check("beq", dut_vec(), 10'b0_10_0_0_1_0_001);
      check("beq_z1", {9'd0, PCSrc}, 10'd1);
      zero = 1'b0; #1;
      check("beq_z0", {9'd0, PCSrc}, 10'd0);
      zero = 1'b1; #1;
      check("beq_z1_again", {9'd0, PCSrc}, 10'd1);
      apply(7'b1101111, 3'b101, 1'b1, 1'b0);
      check("jal", dut_vec(), 10'b1_11_0_0_0_1_000);
      check("jal_pcsrc", {9'd0, PCSrc}, 10'd1);
      apply(7'b0110011, 3'b000, 1'b1, 1'b0);
      check("r_sub", dut_vec(), 10'b1_00_0_0_0_0_001);
      apply(7'b0010011, 3'b000, 1'b1, 1'b0);
      check("addi_f7", dut_vec(), 10'b1_00_1_0_0_0_000);
      apply(7'b0110011, 3'b010, 1'b0, 1'b0);
      check("r_slt", dut_vec(), 10'b1_00_0_0_0_0_101);
      apply(7'b0010011, 3'b110, 1'b0, 1'b0);
      check("i_or", dut_vec(), 10'b1_00_1_0_0_0_011);
      apply(7'b0110011, 3'b111, 1'b0, 1'b0);
      check("r_and", dut_vec(), 10'b1_00_0_0_0_0_010);
      apply(7'b0110011, 3'b001, 1'b0, 1'b0);
      check("r_other_f3", dut_vec(), 10'b1_00_0_0_0_0_000);
      apply(7'b1111111, 3'b000, 1'b1, 1'b1);
      check("illegal", dut_vec(), 10'b0);
      check("illegal_pcsrc", {9'd0, PCSrc}, 10'd0);

      // Reset wins over a jal decode on the same edge.
      @(posedge clk); #1;
      op = 7'b1101111; reset = 1;
      @(posedge clk); #2;
      check("reset_over_jal", dut_vec(), 10'b0);
      reset = 0;

      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         case ($urandom_range(0, 6))
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            default: op = 7'($urandom);
         endcase
         funct3 = 3'($urandom);
         funct7 = 1'($urandom);
         zero   = 1'($urandom);
         reset  = ($urandom_range(0, 19) == 0);
      end
      @(posedge clk); #1;
      reset = 0;
      @(posedge clk); @(negedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
